func_call_arbiter: RTL and testbench

//  Shares one multi-cycle function unit (callee, e.g. a test1_func2-style multiplier)

---
 rtl/func_call_arbiter.sv | 172 +++++++++++++++++
 tb/tb_func_call_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/func_call_arbiter.sv
// Round-robin arbiter sharing one multi-cycle callee between NUM_REQ callers.
// Operands are captured at grant; each caller owns a private result register
// and a done level (out) that follows the request/out level handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no call in flight; pick next requester at or after ptr
// CALL  | callee_req high, waiting for callee_out or a caller abort
// DONE  | call finished or aborted; wait for request and callee_out low
module func_call_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32,
   parameter int IDX_W   = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       request,
   input  logic [NUM_REQ*WIDTH-1:0] in1,
   input  logic [NUM_REQ*WIDTH-1:0] in2,
   output logic [NUM_REQ-1:0]       out,
   output logic [NUM_REQ*WIDTH-1:0] result,
   output logic                     callee_req,
   output logic [WIDTH-1:0]         callee_in1,
   output logic [WIDTH-1:0]         callee_in2,
   input  logic                     callee_out,
   input  logic [WIDTH-1:0]         callee_res
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ-1);

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           ptr_q, ptr_d;
   logic [IDX_W-1:0]           gnt_q, gnt_d;
   logic [NUM_REQ-1:0]         out_d;
   logic [NUM_REQ*WIDTH-1:0]   result_d;
   logic                       callee_req_d;
   logic [WIDTH-1:0]           callee_in1_d, callee_in2_d;

   logic [2*NUM_REQ-1:0]       req_dbl;
   logic [NUM_REQ-1:0]         req_rot;
   logic                       pick_vld;
   logic [IDX_W-1:0]           pick_off;
   logic [IDX_W:0]             pick_sum;
   logic [IDX_W-1:0]           pick_idx;
   logic [WIDTH-1:0]           pick_in1, pick_in2;
   logic [NUM_REQ-1:0]         gnt_oh;
   logic                       req_gnt;

   // Rotate requests so bit 0 is the caller at ptr; search order becomes plain priority.
   assign req_dbl = {request, request};
   assign req_rot = NUM_REQ'(req_dbl >> ptr_q);

   // Lowest rotated offset wins, i.e. first requester at or after ptr.
   always_comb begin
      pick_vld = 1'b0;
      pick_off = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (req_rot[k]) begin
            pick_vld = 1'b1;
            pick_off = IDX_W'(k);
         end
      end
   end

   assign pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
   assign pick_idx = (pick_sum >= NUM_REQ_W) ? IDX_W'(pick_sum - NUM_REQ_W)
                                             : pick_sum[IDX_W-1:0];

   // Operand mux for the candidate caller, captured only when the grant is taken.
   always_comb begin
      pick_in1 = '0;
      pick_in2 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            pick_in1 = in1[i*WIDTH +: WIDTH];
            pick_in2 = in2[i*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot view of the current grant for per-caller updates.
   always_comb begin
      gnt_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt_oh[i] = (gnt_q == IDX_W'(i));
      end
   end

   assign req_gnt = |(request & gnt_oh);

   // Next-state and register updates; everything holds unless the FSM says otherwise.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      gnt_d        = gnt_q;
      out_d        = out;
      result_d     = result;
      callee_req_d = callee_req;
      callee_in1_d = callee_in1;
      callee_in2_d = callee_in2;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_d        = pick_idx;
               callee_in1_d = pick_in1;
               callee_in2_d = pick_in2;
               callee_req_d = 1'b1;
               state_d      = CALL;
            end
         end
         CALL: begin
            // A request drop wins over a simultaneous completion: nothing is written.
            if (!req_gnt) begin
               callee_req_d = 1'b0;
               state_d      = DONE;
            end else if (callee_out) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (gnt_oh[i]) begin
                     result_d[i*WIDTH +: WIDTH] = callee_res;
                  end
               end
               out_d        = out | gnt_oh;
               callee_req_d = 1'b0;
               state_d      = DONE;
            end
         end
         DONE: begin
            out_d = out & (~gnt_oh | request);
            // Waiting for callee_out low keeps callee_req low for a full cycle between calls.
            if (!req_gnt && !callee_out) begin
               out_d   = out & ~gnt_oh;
               ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         gnt_q      <= '0;
         out        <= '0;
         result     <= '0;
         callee_req <= 1'b0;
         callee_in1 <= '0;
         callee_in2 <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         out        <= out_d;
         result     <= result_d;
         callee_req <= callee_req_d;
         callee_in1 <= callee_in1_d;
         callee_in2 <= callee_in2_d;
      end
   end

endmodule

// File: tb/tb_func_call_arbiter.sv
// Bench for func_call_arbiter with a 2-cycle multiplier callee, two callers.
module tb_func_call_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  request;
   logic [63:0] in1, in2;
   logic [1:0]  out;
   logic [63:0] result;
   logic        callee_req;
   logic [31:0] callee_in1, callee_in2;
   logic        callee_out;
   logic [31:0] callee_res;

   logic        c_cnt;

   typedef struct {
      int          idx;
      logic [31:0] res;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [1:0]  prev_out;
   logic        prev_req;
   logic [31:0] prev_in1, prev_in2;

   func_call_arbiter #(.NUM_REQ(2), .WIDTH(32), .IDX_W(1)) dut (
      .clock      (clock),
      .reset      (reset),
      .request    (request),
      .in1        (in1),
      .in2        (in2),
      .out        (out),
      .result     (result),
      .callee_req (callee_req),
      .callee_in1 (callee_in1),
      .callee_in2 (callee_in2),
      .callee_out (callee_out),
      .callee_res (callee_res)
   );

   always #5 clock = ~clock;

   // Callee: done level two edges after it first samples callee_req high.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         c_cnt      <= 1'b0;
         callee_out <= 1'b0;
         callee_res <= '0;
      end else if (!callee_req) begin
         c_cnt      <= 1'b0;
         callee_out <= 1'b0;
      end else if (!callee_out) begin
         if (c_cnt) begin
            callee_out <= 1'b1;
            callee_res <= callee_in1 * callee_in2;
         end else begin
            c_cnt <= 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      in1[i*32 +: 32] = a;
      in2[i*32 +: 32] = b;
   endtask

   // Advance one cycle, check invariants, and retire scoreboard entries on out rises.
   task automatic tick();
      exp_t e;
      @(negedge clock);
      check("out_onehot", 64'($countones(out) <= 1), 64'd1);
      if (out != 2'b00) check("req_low_in_done", 64'(callee_req), 64'd0);
      if (callee_req && !prev_req) check("issue_after_callee_idle", 64'(callee_out), 64'd0);
      if (callee_req && prev_req) begin
         check("callee_in1_stable", 64'(callee_in1), 64'(prev_in1));
         check("callee_in2_stable", 64'(callee_in2), 64'(prev_in2));
      end
      for (int i = 0; i < 2; i++) begin
         if (out[i] && !prev_out[i]) begin
            tests++;
            assert (sb.size() != 0) else begin
               fails++;
               $error("FAIL sb_unexpected_out: out[%0d] rose, observed queue size %0d expected >0", i, sb.size());
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("sb_grant_idx", 64'(i), 64'(e.idx));
               check("sb_result", 64'(result[i*32 +: 32]), 64'(e.res));
            end
         end
      end
      prev_out = out;
      prev_req = callee_req;
      prev_in1 = callee_in1;
      prev_in2 = callee_in2;
   endtask

   task automatic wait_out(input int i, input string tag);
      int n;
      n = 0;
      while (!out[i] && n < 20) begin
         tick();
         n++;
      end
      check(tag, 64'(out[i]), 64'd1);
   endtask

   initial begin
      reset    = 1'b1;
      request  = 2'b00;
      in1      = '0;
      in2      = '0;
      prev_out = 2'b00;
      prev_req = 1'b0;
      prev_in1 = '0;
      prev_in2 = '0;
      repeat (2) @(negedge clock);
      check("rst_out", 64'(out), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_callee_req", 64'(callee_req), 64'd0);
      check("rst_callee_in1", 64'(callee_in1), 64'd0);
      check("rst_callee_in2", 64'(callee_in2), 64'd0);
      reset = 1'b0;

      // 1: single call, latency, hold, release
      set_ops(0, 32'd3, 32'd7);
      sb.push_back('{0, 32'd21});
      request[0] = 1'b1;
      tick();
      check("t1_callee_req", 64'(callee_req), 64'd1);
      check("t1_callee_in1", 64'(callee_in1), 64'd3);
      check("t1_callee_in2", 64'(callee_in2), 64'd7);
      tick();
      tick();
      check("t1_out_not_early", 64'(out), 64'd0);
      tick();
      check("t1_out0_rise", 64'(out), 64'd1);
      tick();
      tick();
      check("t1_out0_hold", 64'(out), 64'd1);
      check("t1_result0", 64'(result[31:0]), 64'd21);
      check("t1_callee_req_done", 64'(callee_req), 64'd0);
      request[0] = 1'b0;
      tick();
      check("t1_out0_clear", 64'(out), 64'd0);
      tick();
      tick();

      // 2: simultaneous requests after reset, caller 0 first
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_ops(0, 32'd3, 32'd7);
      set_ops(1, 32'd7, 32'd10);
      sb.push_back('{0, 32'd21});
      sb.push_back('{1, 32'd70});
      request = 2'b11;
      wait_out(0, "t2_out0");
      request[0] = 1'b0;
      wait_out(1, "t2_out1");
      check("t2_result0_kept", 64'(result[31:0]), 64'd21);
      check("t2_result1", 64'(result[63:32]), 64'd70);
      request[1] = 1'b0;
      repeat (3) tick();

      // 3: both callers re-request continuously, strict alternation
      set_ops(0, 32'd2, 32'd3);
      set_ops(1, 32'd4, 32'd5);
      sb.push_back('{0, 32'd6});
      sb.push_back('{1, 32'd20});
      request = 2'b11;
      for (int n = 0; n < 6; n++) begin
         int who;
         who = n % 2;
         wait_out(who, "t3_out_in_order");
         request[who] = 1'b0;
         tick();
         tick();
         if (n < 4) begin
            set_ops(who, 32'(n + 5), 32'(n + 11));
            sb.push_back('{who, 32'((n + 5) * (n + 11))});
            request[who] = 1'b1;
         end
      end
      check("t3_sb_drained", 64'(sb.size()), 64'd0);
      repeat (3) tick();

      // 4: caller 1 aborts during CALL, then ptr has wrapped to 0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_ops(1, 32'd4, 32'd5);
      request[1] = 1'b1;
      tick();
      check("t4_callee_req_on", 64'(callee_req), 64'd1);
      request[1] = 1'b0;
      tick();
      check("t4_callee_req_off", 64'(callee_req), 64'd0);
      repeat (3) tick();
      check("t4_out_never", 64'(out), 64'd0);
      check("t4_result1_kept", 64'(result[63:32]), 64'd0);
      set_ops(0, 32'd8, 32'd9);
      set_ops(1, 32'd6, 32'd7);
      sb.push_back('{0, 32'd72});
      sb.push_back('{1, 32'd42});
      request = 2'b11;
      wait_out(0, "t4_ptr0_out0");
      request[0] = 1'b0;
      wait_out(1, "t4_ptr0_out1");
      request[1] = 1'b0;
      repeat (3) tick();

      // 4b: request drops on the edge that first samples callee_out high
      set_ops(0, 32'd6, 32'd6);
      request[0] = 1'b1;
      repeat (3) tick();
      check("t4b_callee_out", 64'(callee_out), 64'd1);
      check("t4b_out_before", 64'(out), 64'd0);
      request[0] = 1'b0;
      tick();
      check("t4b_out_after", 64'(out), 64'd0);
      repeat (3) tick();
      check("t4b_result0_kept", 64'(result[31:0]), 64'd72);

      // 5: reset mid-CALL clears immediately, fresh call afterwards
      set_ops(0, 32'd11, 32'd13);
      request[0] = 1'b1;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("t5_out_clear", 64'(out), 64'd0);
      check("t5_callee_req_clear", 64'(callee_req), 64'd0);
      check("t5_result_clear", result, 64'd0);
      check("t5_callee_in1_clear", 64'(callee_in1), 64'd0);
      request = 2'b00;
      #1;
      reset = 1'b0;
      tick();
      tick();
      check("t5_no_stale_out", 64'(out), 64'd0);
      set_ops(0, 32'd2, 32'd9);
      sb.push_back('{0, 32'd18});
      request[0] = 1'b1;
      wait_out(0, "t5_out0");
      check("t5_result0", 64'(result[31:0]), 64'd18);
      request[0] = 1'b0;
      repeat (3) tick();

      // 6: operand change after grant is ignored
      set_ops(0, 32'd3, 32'd7);
      sb.push_back('{0, 32'd21});
      request[0] = 1'b1;
      tick();
      set_ops(0, 32'd5, 32'd7);
      tick();
      check("t6_callee_in1_held", 64'(callee_in1), 64'd3);
      tick();
      wait_out(0, "t6_out0");
      check("t6_result0", 64'(result[31:0]), 64'd21);
      check("t6_callee_in1_final", 64'(callee_in1), 64'd3);
      request[0] = 1'b0;
      repeat (3) tick();
      check("t6_out_clear", 64'(out), 64'd0);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
